// File: rtl/reaction_controller.sv
// Reaction-time game controller: random pre-stimulus delay, lamp, false-start
// and no-response detection, and a best-time register in 3-digit BCD.
module reaction_controller #(
  parameter int unsigned DELAY_MIN_MS = 1000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       button,
  input  logic [3:0] cnt_bcd2,
  input  logic [3:0] cnt_bcd1,
  input  logic [3:0] cnt_bcd0,
  output logic       cnt_clear,
  output logic       cnt_enable,
  output logic       led,
  output logic       foul,
  output logic       timeout,
  output logic [3:0] best_bcd2,
  output logic [3:0] best_bcd1,
  output logic [3:0] best_bcd0,
  output logic [2:0] state_o
);

  localparam int unsigned LFSR_W  = 10;
  localparam int unsigned DELAY_W = 13;
  localparam int unsigned BCD_W   = 12;
  localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);
  localparam logic [BCD_W-1:0]  BCD_MAX   = 12'h999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_FOUL  = 3'd4,
    ST_TOUT  = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [DELAY_W-1:0]  delay_q;
  logic [BCD_W-1:0]    best_q;
  logic [BCD_W-1:0]    count_c;
  logic                start_c;
  logic                load_best_c;

  // BCD digits compare correctly as one unsigned word, MSD first
  assign count_c = {cnt_bcd2, cnt_bcd1, cnt_bcd0};

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, trial start, best-load strobe and counter enable
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    load_best_c = 1'b0;
    cnt_enable  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL, ST_TOUT: begin
        if (button) begin
          state_d = ST_WAIT;
          start_c = 1'b1;
        end
      end
      ST_WAIT: begin
        if (button) begin
          state_d = ST_FOUL;
        end else if (tick && (delay_q < DELAY_W'(2))) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (button) begin
          state_d     = ST_DONE;
          load_best_c = (count_c < best_q);
        end else if (tick) begin
          if (count_c == BCD_MAX) begin
            state_d = ST_TOUT;
          end else begin
            cnt_enable = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // inputs are ignored while clear is high
    if (clear) begin
      state_d     = ST_IDLE;
      start_c     = 1'b0;
      load_best_c = 1'b0;
      cnt_enable  = 1'b0;
    end
  end

  // LFSR, delay countdown, best time and counter-clear register
  always_ff @(posedge clock) begin
    if (clear) begin
      lfsr_q    <= LFSR_SEED;
      delay_q   <= '0;
      best_q    <= BCD_MAX;
      cnt_clear <= 1'b1;
    end else begin
      lfsr_q    <= {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
      cnt_clear <= start_c;
      if (start_c) begin
        delay_q <= DELAY_W'(DELAY_MIN_MS) + DELAY_W'(lfsr_q);
      end else if ((state_q == ST_WAIT) && tick && (delay_q != '0)) begin
        delay_q <= delay_q - DELAY_W'(1);
      end
      if (load_best_c) begin
        best_q <= count_c;
      end
    end
  end

  assign led       = (state_q == ST_ARMED);
  assign foul      = (state_q == ST_FOUL);
  assign timeout   = (state_q == ST_TOUT);
  assign state_o   = state_q;
  assign best_bcd2 = best_q[11:8];
  assign best_bcd1 = best_q[7:4];
  assign best_bcd0 = best_q[3:0];

endmodule

// File: tb/tb_reaction_controller.sv
// Bench for reaction_controller: emulated time counter plus a trial-level model.
module tb_reaction_controller;

  localparam int DMIN = 2;

  logic       clock  = 1'b0;
  logic       clear  = 1'b1;
  logic       tick   = 1'b0;
  logic       button = 1'b0;
  logic [3:0] cnt_bcd2, cnt_bcd1, cnt_bcd0;
  logic       cnt_clear, cnt_enable, led, foul, timeout;
  logic [3:0] best_bcd2, best_bcd1, best_bcd0;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  // environment time counter (decimal, wraps like a free BCD counter)
  int env_cnt = 0;

  // model: state code, remaining delay ticks, lfsr, expected count, best
  int m_state = 0;
  int m_delay = 0;
  int m_lfsr  = 1;
  int m_count = 0;
  int m_best  = 999;
  bit m_clr   = 1'b0;
  bit m_en    = 1'b0;
  logic en_obs;

  reaction_controller #(.DELAY_MIN_MS(DMIN)) dut (
    .clock(clock), .clear(clear), .tick(tick), .button(button),
    .cnt_bcd2(cnt_bcd2), .cnt_bcd1(cnt_bcd1), .cnt_bcd0(cnt_bcd0),
    .cnt_clear(cnt_clear), .cnt_enable(cnt_enable), .led(led),
    .foul(foul), .timeout(timeout),
    .best_bcd2(best_bcd2), .best_bcd1(best_bcd1), .best_bcd0(best_bcd0),
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  assign cnt_bcd2 = 4'(env_cnt / 100);
  assign cnt_bcd1 = 4'((env_cnt / 10) % 10);
  assign cnt_bcd0 = 4'(env_cnt % 10);

  always @(posedge clock) begin
    if (cnt_clear === 1'b1) env_cnt <= 0;
    else if (cnt_enable === 1'b1) env_cnt <= (env_cnt + 1) % 1000;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int lfsr_next(input int x);
    return ((x << 1) & 32'h3FF) | (((x >> 9) ^ (x >> 6)) & 1);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {3'(m_state), 1'(m_state == 2), 1'(m_state == 4), 1'(m_state == 5),
            m_clr, m_en, to_bcd(m_best), to_bcd(m_count)};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {state_o, led, foul, timeout, cnt_clear, en_obs,
            best_bcd2, best_bcd1, best_bcd0, cnt_bcd2, cnt_bcd1, cnt_bcd0};
  endfunction

  function automatic logic [11:0] obs_best();
    return {best_bcd2, best_bcd1, best_bcd0};
  endfunction

  function automatic logic [11:0] obs_cnt();
    return {cnt_bcd2, cnt_bcd1, cnt_bcd0};
  endfunction

  // one clock: drive at negedge, sample enable, advance the model at posedge
  task automatic cycle(input logic c, input logic b, input logic t);
    int cur_count;
    bit clr_now;
    @(negedge clock);
    clear = c; button = b; tick = t;
    #1;
    en_obs = cnt_enable;
    m_en = !c && (m_state == 2) && t && !b && (m_count != 999);
    @(posedge clock);
    cur_count = m_count;
    clr_now   = m_clr;
    if (clr_now) m_count = 0;
    else if (m_en) m_count = m_count + 1;
    if (c) begin
      m_state = 0; m_best = 999; m_lfsr = 1; m_clr = 1'b1; m_delay = 0;
    end else begin
      m_clr = 1'b0;
      case (m_state)
        1: begin
          if (b) m_state = 4;
          else if (t) begin
            if (m_delay <= 1) m_state = 2;
            else m_delay = m_delay - 1;
          end
        end
        2: begin
          if (b) begin
            m_state = 3;
            if (cur_count < m_best) m_best = cur_count;
          end else if (t && cur_count == 999) m_state = 5;
        end
        default: begin
          if (b) begin
            m_state = 1; m_delay = DMIN + m_lfsr; m_clr = 1'b1;
          end
        end
      endcase
      m_lfsr = lfsr_next(m_lfsr);
    end
    #1;
  endtask

  // start a trial and tick through the delay; no checking here
  task automatic go_armed(output bit ok);
    int n = 0;
    cycle(1'b0, 1'b1, 1'b0);
    while (m_state != 2 && n < 6000) begin
      cycle(1'b0, 1'b0, 1'b1);
      n++;
    end
    ok = (m_state == 2);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (state_o !== 3'd0 || obs_best() !== 12'h999 || cnt_clear !== 1'b1 || led !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: got st=%0d best=%h clr=%b led=%b want st=0 best=999 clr=1 led=0",
               state_o, obs_best(), cnt_clear, led);
    end
  endtask

  task automatic test_first_trial();
    int n = 0;
    int ticks = 0;
    cycle(1'b0, 1'b0, 1'b0);
    while (m_lfsr != 5 && n < 1100) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 1100) begin
      failures++;
      $display("FAIL lfsr_wait: got no lfsr=5 within %0d cycles want lfsr=5", n);
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'd1 || cnt_clear !== 1'b1) begin
      failures++;
      $display("FAIL trial_start: got st=%0d clr=%b want st=1 clr=1", state_o, cnt_clear);
    end
    while (state_o !== 3'd2 && ticks < 20) begin
      cycle(1'b0, 1'b0, 1'b1);
      ticks++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wait_vec: got %h want %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (ticks != 7 || led !== 1'b1) begin
      failures++;
      $display("FAIL wait_ticks: got ticks=%0d led=%b want ticks=7 led=1", ticks, led);
    end
    for (int i = 0; i < 123; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL armed_vec: got %h want %h", obs_vec(), exp_vec());
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'd3 || obs_cnt() !== 12'h123 || obs_best() !== 12'h123) begin
      failures++;
      $display("FAIL first_done: got st=%0d cnt=%h best=%h want st=3 cnt=123 best=123",
               state_o, obs_cnt(), obs_best());
    end
  endtask

  task automatic test_best_update();
    bit ok;
    int resp [2] = '{200, 50};
    logic [11:0] want [2] = '{12'h123, 12'h050};
    for (int k = 0; k < 2; k++) begin
      go_armed(ok);
      checks++;
      if (!ok || state_o !== 3'd2) begin
        failures++;
        $display("FAIL best_armed: got st=%0d want st=2", state_o);
      end
      for (int i = 0; i < resp[k]; i++) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      checks++;
      if (state_o !== 3'd3 || obs_best() !== want[k] || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL best_update: got st=%0d best=%h vec=%h want st=3 best=%h vec=%h",
                 state_o, obs_best(), obs_vec(), want[k], exp_vec());
      end
    end
  endtask

  task automatic test_foul();
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'd4 || foul !== 1'b1 || led !== 1'b0 || obs_best() !== 12'h050) begin
      failures++;
      $display("FAIL foul_enter: got st=%0d foul=%b led=%b best=%h want st=4 foul=1 led=0 best=050",
               state_o, foul, led, obs_best());
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (state_o !== 3'd1 || cnt_clear !== 1'b1 || foul !== 1'b0) begin
      failures++;
      $display("FAIL foul_restart: got st=%0d clr=%b foul=%b want st=1 clr=1 foul=0",
               state_o, cnt_clear, foul);
    end
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (state_o !== 3'd4 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL foul_tick_button: got st=%0d vec=%h want st=4 vec=%h",
               state_o, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    go_armed(ok);
    checks++;
    if (!ok || state_o !== 3'd2) begin
      failures++;
      $display("FAIL tout_armed: got st=%0d want st=2", state_o);
    end
    for (int i = 0; i < 999; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL tout_vec: got %h want %h", obs_vec(), exp_vec());
      end
    end
    checks++;
    if (state_o !== 3'd2 || obs_cnt() !== 12'h999) begin
      failures++;
      $display("FAIL tout_pre: got st=%0d cnt=%h want st=2 cnt=999", state_o, obs_cnt());
    end
    cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (state_o !== 3'd5 || timeout !== 1'b1 || en_obs !== 1'b0 || obs_best() !== 12'h050) begin
      failures++;
      $display("FAIL tout_enter: got st=%0d to=%b en=%b best=%h want st=5 to=1 en=0 best=050",
               state_o, timeout, en_obs, obs_best());
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_cnt() !== 12'h999 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL tout_hold: got cnt=%h to=%b want cnt=999 to=1", obs_cnt(), timeout);
    end
  endtask

  task automatic test_clear_mid();
    bit ok;
    go_armed(ok);
    for (int i = 0; i < 42; i++) cycle(1'b0, 1'b0, 1'b1);
    checks++;
    if (!ok || obs_cnt() !== 12'h042 || led !== 1'b1) begin
      failures++;
      $display("FAIL clr_pre: got cnt=%h led=%b want cnt=042 led=1", obs_cnt(), led);
    end
    cycle(1'b1, 1'b1, 1'b1);
    checks++;
    if (state_o !== 3'd0 || led !== 1'b0 || cnt_clear !== 1'b1 || obs_best() !== 12'h999) begin
      failures++;
      $display("FAIL clr_armed: got st=%0d led=%b clr=%b best=%h want st=0 led=0 clr=1 best=999",
               state_o, led, cnt_clear, obs_best());
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    checks++;
    if (state_o !== 3'd0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL clr_wait: got st=%0d vec=%h want st=0 vec=%h", state_o, obs_vec(), exp_vec());
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_coincide();
    bit ok;
    go_armed(ok);
    for (int i = 0; i < 999; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    checks++;
    if (!ok || state_o !== 3'd3 || obs_cnt() !== 12'h999 || obs_best() !== 12'h999 || en_obs !== 1'b0) begin
      failures++;
      $display("FAIL coincide: got st=%0d cnt=%h best=%h en=%b want st=3 cnt=999 best=999 en=0",
               state_o, obs_cnt(), obs_best(), en_obs);
    end
  endtask

  task automatic test_random();
    logic c, b, t;
    for (int i = 0; i < 20000; i++) begin
      c = 1'($urandom_range(0, 1499) == 0);
      b = 1'($urandom_range(0, 249) == 0);
      t = 1'($urandom_range(0, 3) != 0);
      cycle(c, b, t);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_vec: cycle %0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_trial();
    test_best_update();
    test_foul();
    test_timeout();
    test_clear_mid();
    test_coincide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_controller.md
REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 SHALL have parameter DELAY_MIN_MS, default 1000: minimum random pre-stimulus delay, in ticks; legal range 0..4000.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on posedge clock.
REQ-003 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port tick, input, 1: one-cycle 1 ms timebase pulse.
REQ-005 SHALL have port button, input, 1: one-cycle pulse, already debounced and edge-detected.
REQ-006 SHALL have ports cnt_bcd2, cnt_bcd1, cnt_bcd0, each input, 4: current 3-digit BCD count from the time counter.
REQ-007 SHALL have port cnt_clear, output, 1: synchronous clear to the time counter.
REQ-008 SHALL have port cnt_enable, output, 1: increment enable to the time counter.
REQ-009 SHALL have port led, output, 1: stimulus lamp.
REQ-010 SHALL have port foul, output, 1: false-start indicator.
REQ-011 SHALL have port timeout, output, 1: no-response indicator.
REQ-012 SHALL have ports best_bcd2, best_bcd1, best_bcd0, each output, 4: best valid time in BCD.
REQ-013 SHALL have port state_o, output, 3: encoded current state, for display and debug.

Function
REQ-014 SHALL implement states IDLE=0, WAIT=1, ARMED=2, DONE=3, FOUL=4, TOUT=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-015 SHALL run a 10-bit Fibonacci LFSR (taps 10,7) every cycle, seeded to 10'h001, never entering all-zero.
REQ-016 From IDLE, button SHALL load delay_cnt (13 bits) = DELAY_MIN_MS + lfsr, assert cnt_clear for that one cycle, and enter WAIT.
REQ-017 In WAIT, delay_cnt SHALL decrement on each tick.
REQ-018 In WAIT, a tick with delay_cnt==1 (or delay_cnt==0 on entry) SHALL enter ARMED.
REQ-019 In WAIT, button SHALL enter FOUL; button takes priority over tick in the same cycle.
REQ-020 In ARMED, led SHALL be 1 and cnt_enable SHALL equal tick, combinationally.
REQ-021 In ARMED, button SHALL enter DONE with cnt_enable forced 0 that cycle; the counter holds the reaction time.
REQ-022 In ARMED, a tick while the count is 9,9,9 with no button SHALL enter TOUT with cnt_enable forced 0; the counter holds 999 and never wraps.
REQ-023 In ARMED, when button and the timeout tick coincide, button SHALL win and the block SHALL enter DONE with a result of 999.
REQ-024 On the cycle DONE is entered, if the count is less than best (3-digit BCD compare, most-significant digit first), best SHALL load the count; equal counts SHALL leave best unchanged.
REQ-025 FOUL and TOUT SHALL never update best.
REQ-026 foul SHALL be 1 only in FOUL; timeout SHALL be 1 only in TOUT; led SHALL be 0 outside ARMED.
REQ-027 From DONE, FOUL or TOUT, button SHALL behave exactly as in IDLE (new trial: cnt_clear pulse, then WAIT).
REQ-028 cnt_clear SHALL be 1 only on trial-start cycles and during reset; cnt_enable SHALL be 0 outside ARMED.
REQ-029 All outputs other than cnt_enable SHALL be registered or decoded directly from state.

Reset
REQ-030 While clear is high: state=IDLE; best=9,9,9; led=0; foul=0; timeout=0; cnt_enable=0; cnt_clear=1; delay_cnt=0; LFSR=10'h001.
REQ-031 Asserting clear in any state, including mid-WAIT or mid-ARMED, SHALL abort the trial and the reset values SHALL take effect on the next edge.
REQ-032 The tick and button inputs SHALL be ignored in any cycle where clear is high.

Verification
REQ-033 DELAY_MIN_MS=2; button at LFSR=5 -> WAIT for exactly 7 ticks; ARMED, led=1; button after 123 ticks -> DONE, count=1,2,3, best=1,2,3.
REQ-034 Second trial with a 200-tick response -> DONE, best stays 1,2,3; third trial with a 050-tick response -> best=0,5,0.
REQ-035 Button during WAIT -> FOUL, foul=1, led never 1, best unchanged; next button -> cnt_clear pulse and WAIT.
REQ-036 No button in ARMED -> after 999 ticks the next tick gives TOUT, timeout=1, count holds 999, best unchanged.
REQ-037 clear asserted mid-ARMED with count=0,4,2 -> next cycle IDLE, led=0, cnt_clear=1, best=9,9,9.
REQ-038 Button and timeout tick in the same cycle -> DONE, best=9,9,9 (equal, so no change); tick and button in the same WAIT cycle -> FOUL.
